// File: rtl/ps2_rx_if.sv
// rtl/ps2_rx_if.sv - PS/2 line inputs and received-byte outputs of ps2_rx
interface ps2_rx_if;
    logic       i_ps2_clk;
    logic       i_ps2_data;
    logic [7:0] o_count;
    logic       o_ready;
    logic       o_error;

    modport master (
        input  i_ps2_clk,
        input  i_ps2_data,
        output o_count,
        output o_ready,
        output o_error
    );

    modport slave (
        output i_ps2_clk,
        output i_ps2_data,
        input  o_count,
        input  o_ready,
        input  o_error
    );
endinterface

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host frame receiver with filtered clock and timeout
// Optional break-code suppression is enabled by defining PS2_BREAK_FILTER_EN.
module ps2_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic      i_clk,
    input  logic      i_reset,
    ps2_rx_if.master  bus
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_s;
    logic                   data_s;

    logic [FLT_W-1:0]       flt_cnt_q;
    logic                   filt_q;
    logic                   fall_tick;

    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [7:0]             count_q, count_d;
    logic                   ready_q, ready_d;
    logic                   error_q, error_d;
    logic                   emit_q, emit_d;
    logic                   emit_ok;
    logic                   frame_ok;
`ifdef PS2_BREAK_FILTER_EN
    logic                   brk_q, brk_d;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.i_ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.i_ps2_data};
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // The filtered clock only moves after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            flt_cnt_q <= '0;
            filt_q    <= 1'b1;
            fall_tick <= 1'b0;
        end else begin
            fall_tick <= 1'b0;
            if (clk_s != filt_q) begin
                if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                    filt_q    <= clk_s;
                    flt_cnt_q <= '0;
                    fall_tick <= filt_q;
                end else begin
                    flt_cnt_q <= flt_cnt_q + 1'b1;
                end
            end else begin
                flt_cnt_q <= '0;
            end
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    assign emit_ok = !brk_q && (shift_q != 8'hF0);
`else
    assign emit_ok = 1'b1;
`endif

    // Odd parity over the eight data bits plus the parity bit.
    assign frame_ok = data_s && (^{shift_q, parity_q});

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            to_cnt_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            emit_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            to_cnt_q  <= to_cnt_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            emit_q    <= emit_d;
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            brk_q <= 1'b0;
        end else begin
            brk_q <= brk_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        to_cnt_d  = to_cnt_q;
        count_d   = count_q;
        ready_d   = 1'b0;
        error_d   = 1'b0;
        emit_d    = emit_q;
`ifdef PS2_BREAK_FILTER_EN
        brk_d     = brk_q;
`endif

        case (state_q)
            IDLE: begin
                to_cnt_d  = '0;
                bit_cnt_d = '0;
                if (fall_tick && !data_s) begin
                    shift_d = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (fall_tick) begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall_tick) begin
                    parity_d = data_s;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall_tick) begin
                    if (frame_ok) begin
                        // Byte lands on o_count a cycle ahead of the o_ready strobe.
                        emit_d  = emit_ok;
                        if (emit_ok) begin
                            count_d = shift_q;
                        end
                        state_d = DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                ready_d  = emit_q;
                to_cnt_d = '0;
`ifdef PS2_BREAK_FILTER_EN
                brk_d    = !brk_q && (shift_q == 8'hF0);
`endif
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog runs only while a frame is partially received.
        if ((state_q == DATA || state_q == PARITY || state_q == STOP) && !fall_tick) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                error_d  = 1'b1;
                shift_d  = '0;
                to_cnt_d = '0;
                state_d  = IDLE;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else if (fall_tick) begin
            to_cnt_d = '0;
        end

`ifdef PS2_BREAK_FILTER_EN
        if (error_d) begin
            brk_d = 1'b0;
        end
`endif
    end

    assign bus.o_count = count_q;
    assign bus.o_ready = ready_q;
    assign bus.o_error = error_q;

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - scoreboard bench for ps2_rx with directed PS/2 frames
module tb_ps2_rx;

    localparam int SYNC    = 2;
    localparam int FILT    = 8;
    localparam int TO      = 200;
    localparam int HALF    = 20;
    localparam int RDY_LAT = SYNC + FILT + 2;
    localparam int ERR_LAT = SYNC + FILT + 1;
    localparam int TO_LAT  = SYNC + FILT + 1 + TO;

    localparam int K_NONE  = 0;
    localparam int K_READY = 1;
    localparam int K_ERR   = 2;
    localparam int K_TO    = 3;

    typedef struct {
        bit         is_err;
        logic [7:0] val;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [7:0] held = 8'h00;
    bit   brk = 1'b0;
    exp_t exp_q[$];
    exp_t e;

    ps2_rx_if bus ();

    ps2_rx #(
        .SYNC_STAGES   (SYNC),
        .FILTER_LEN    (FILT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.o_ready || bus.o_error)) begin
            check("strobes exclusive", int'(bus.o_ready & bus.o_error), 0);
            if (exp_q.size() == 0) begin
                check("unexpected strobe (ready<<1|error)", int'({bus.o_ready, bus.o_error}), 0);
            end else begin
                e = exp_q.pop_front();
                check("strobe kind is_error", int'(bus.o_error), int'(e.is_err));
                check("o_count at strobe", int'(bus.o_count), int'(e.val));
                check("strobe cycle", cyc, e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input bit bad_par, input bit stop);
        return {stop, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    task automatic push(input int kind, input int at);
        exp_t x;
        if (kind == K_READY) begin
            x.is_err = 1'b0; x.val = held; x.cyc = at + RDY_LAT;
            exp_q.push_back(x);
        end else if (kind == K_ERR || kind == K_TO) begin
            x.is_err = 1'b1; x.val = held;
            x.cyc = at + ((kind == K_TO) ? TO_LAT : ERR_LAT);
            exp_q.push_back(x);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n, input int kind);
        for (int i = 0; i < n; i++) begin
            bus.i_ps2_data = bits[i];
            idle(HALF);
            bus.i_ps2_clk = 1'b0;
            if (i == n - 1) push(kind, cyc);
            idle(HALF);
            bus.i_ps2_clk = 1'b1;
        end
        bus.i_ps2_data = 1'b1;
        idle(HALF);
    endtask

    task automatic good(input logic [7:0] d);
        int kind;
        kind = K_READY;
`ifdef PS2_BREAK_FILTER_EN
        if (brk) begin
            brk = 1'b0; kind = K_NONE;
        end else if (d == 8'hF0) begin
            brk = 1'b1; kind = K_NONE;
        end
`endif
        if (kind == K_READY) held = d;
        send_bits(frame(d, 1'b0, 1'b1), 11, kind);
        idle(30);
    endtask

    task automatic bad(input logic [7:0] d, input bit bad_par, input bit stop);
        brk = 1'b0;
        send_bits(frame(d, bad_par, stop), 11, K_ERR);
        idle(30);
    endtask

    initial begin
        bus.i_ps2_clk  = 1'b1;
        bus.i_ps2_data = 1'b1;
        rst = 1'b1;
        idle(3);
        #1;
        check("reset o_count", int'(bus.o_count), 0);
        check("reset o_ready", int'(bus.o_ready), 0);
        check("reset o_error", int'(bus.o_error), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(20);

        good(8'h1C);
        bad(8'h1C, 1'b1, 1'b1);
        bad(8'h45, 1'b0, 1'b0);
        good(8'h16);

        brk = 1'b0;
        send_bits(frame(8'h33, 1'b0, 1'b1), 6, K_TO);
        idle(TO + 60);
        good(8'h1C);

        bus.i_ps2_clk = 1'b0;
        idle(3);
        bus.i_ps2_clk = 1'b1;
        idle(40);

        good(8'h1C);
        good(8'hF0);
        good(8'h1C);

        send_bits(frame(8'h5A, 1'b0, 1'b1), 4, K_NONE);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid-frame reset o_count", int'(bus.o_count), 0);
        check("mid-frame reset o_ready", int'(bus.o_ready), 0);
        check("mid-frame reset o_error", int'(bus.o_error), 0);
        held = 8'h00;
        brk  = 1'b0;
        idle(5);
        rst = 1'b0;
        idle(30);
        good(8'h5A);

        idle(100);
        check("pending expected strobes", exp_q.size(), 0);
        check("final o_count", int'(bus.o_count), 8'h5A);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
